// File: rtl/lisp_eval_core_if.sv
// rtl/lisp_eval_core_if.sv - cell-memory read port between evaluator and cell store
interface lisp_eval_core_if #(
    parameter int WORD_W = 16
) ();
    logic              mem_req;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_ready;
    logic [14:0]       mem_header;
    logic [WORD_W-1:0] mem_car;
    logic [WORD_W-1:0] mem_cdr;

    modport master (
        output mem_req, mem_addr,
        input  mem_ready, mem_header, mem_car, mem_cdr
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ready, mem_header, mem_car, mem_cdr
    );
endinterface

// File: rtl/lisp_eval_core.sv
// rtl/lisp_eval_core.sv - iterative Lisp expression evaluator with explicit frame stack
module lisp_eval_core #(
    parameter int WORD_W      = 16,
    parameter int STACK_DEPTH = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [WORD_W-1:0]                expr_addr,
    lisp_eval_core_if.master                 mem,
    output logic                             busy,
    output logic                             done,
    output logic [WORD_W-1:0]                result,
    output logic                             error,
    output logic [3:0]                       error_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth
);
    localparam int DW    = $clog2(STACK_DEPTH + 1);
    localparam int AW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << AW;
    localparam int TW    = $clog2(MEM_TIMEOUT + 1);

    // Cell type tags and primitive opcodes shared with the cell store
    localparam logic [14:0]       TYPE_NUMBER    = 15'd1;
    localparam logic [14:0]       TYPE_CONS      = 15'd2;
    localparam logic [14:0]       TYPE_PRIMITIVE = 15'd3;
    localparam logic [WORD_W-1:0] LISP_NIL       = '0;
    localparam logic [WORD_W-1:0] PRIMOP_ADD     = WORD_W'(0);
    localparam logic [WORD_W-1:0] PRIMOP_SUB     = WORD_W'(1);
    localparam logic [WORD_W-1:0] PRIMOP_MUL     = WORD_W'(2);
    localparam logic [WORD_W-1:0] PRIMOP_AND     = WORD_W'(3);
    localparam logic [WORD_W-1:0] PRIMOP_OR      = WORD_W'(4);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_MEM_WAIT, S_EVAL, S_APPLY,
        S_EVAL_ARGS, S_COMBINE, S_RETURN, S_DONE, S_ERROR
    } state_t;

    // Where MemWait hands the freshly read cell
    typedef enum logic [1:0] {C_EVAL, C_APPLY, C_ARGS, C_ARG} cont_t;

    state_t             r_state, w_state_next;
    cont_t              r_cont, w_rd_cont;
    logic               r_mem_req;
    logic [WORD_W-1:0]  r_mem_addr, w_rd_addr;
    logic [TW-1:0]      r_wait;
    logic [WORD_W-1:0]  r_root;
    logic [14:0]        r_hdr;
    logic [WORD_W-1:0]  r_car, r_cdr;
    logic [WORD_W-1:0]  r_op, r_acc, r_args, r_value, r_result;
    logic               r_first;
    logic [DW-1:0]      r_depth;
    logic [3:0]         r_err_code, w_err_code;
    logic               w_rd, w_push, w_pop;

    logic [WORD_W-1:0]  r_stk_op    [0:SLOTS-1];
    logic [WORD_W-1:0]  r_stk_acc   [0:SLOTS-1];
    logic [WORD_W-1:0]  r_stk_args  [0:SLOTS-1];
    logic               r_stk_first [0:SLOTS-1];

    logic               w_is_num, w_is_cons, w_is_prim, w_args_nil, w_full, w_depth0;
    logic               w_op_ok;
    logic [WORD_W-1:0]  w_alu, w_comb_val;
    logic [AW-1:0]      w_push_idx, w_pop_idx;

    assign w_is_num   = (r_hdr == TYPE_NUMBER);
    assign w_is_cons  = (r_hdr == TYPE_CONS);
    assign w_is_prim  = (r_hdr == TYPE_PRIMITIVE);
    assign w_args_nil = (r_args == LISP_NIL);
    assign w_full     = (r_depth == DW'(STACK_DEPTH));
    assign w_depth0   = (r_depth == '0);
    assign w_push_idx = AW'(r_depth);
    assign w_pop_idx  = AW'(r_depth - DW'(1));
    assign w_comb_val = r_first ? r_value : w_alu;

    // Accumulator operation; all results wrap at WORD_W bits
    always_comb begin
        w_op_ok = 1'b1;
        w_alu   = r_acc;
        case (r_op)
            PRIMOP_ADD: w_alu = r_acc + r_value;
            PRIMOP_SUB: w_alu = r_acc - r_value;
            PRIMOP_MUL: w_alu = r_acc * r_value;
            PRIMOP_AND: w_alu = r_acc & r_value;
            PRIMOP_OR:  w_alu = r_acc | r_value;
            default:    w_op_ok = 1'b0;
        endcase
    end

    // Next state, cell-read issue, stack push/pop and fault cause
    always_comb begin
        w_state_next = r_state;
        w_err_code   = 4'd0;
        w_rd         = 1'b0;
        w_rd_addr    = r_mem_addr;
        w_rd_cont    = r_cont;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_rd = 1'b1; w_rd_addr = r_root; w_rd_cont = C_EVAL;
            end
            S_MEM_WAIT: begin
                if (mem.mem_ready) begin
                    case (r_cont)
                        C_EVAL:  w_state_next = S_EVAL;
                        C_APPLY: w_state_next = S_APPLY;
                        default: w_state_next = S_EVAL_ARGS;
                    endcase
                end else if (r_wait == TW'(MEM_TIMEOUT - 1)) begin
                    w_state_next = S_ERROR; w_err_code = 4'd1;
                end
            end
            S_EVAL: begin
                if (w_is_num) begin
                    w_state_next = w_depth0 ? S_DONE : S_RETURN;
                end else if (w_is_cons) begin
                    w_rd = 1'b1; w_rd_addr = r_car; w_rd_cont = C_APPLY;
                end else begin
                    w_state_next = S_ERROR; w_err_code = 4'd2;
                end
            end
            S_APPLY: begin
                if (!w_is_prim) begin
                    w_state_next = S_ERROR; w_err_code = 4'd3;
                end else if (w_args_nil) begin
                    w_state_next = S_ERROR; w_err_code = 4'd5;
                end else begin
                    w_rd = 1'b1; w_rd_addr = r_args; w_rd_cont = C_ARGS;
                end
            end
            S_EVAL_ARGS: begin
                if (r_cont == C_ARG) begin
                    if (w_is_num) begin
                        w_state_next = S_COMBINE;
                    end else if (w_is_cons && !w_full) begin
                        w_push = 1'b1; w_state_next = S_EVAL;
                    end else begin
                        w_state_next = S_ERROR;
                        w_err_code   = w_is_cons ? 4'd4 : 4'd2;
                    end
                end else if (!w_is_cons) begin
                    w_state_next = S_ERROR; w_err_code = 4'd2;
                end else begin
                    w_rd = 1'b1; w_rd_addr = r_car; w_rd_cont = C_ARG;
                end
            end
            S_COMBINE: begin
                if (!r_first && !w_op_ok) begin
                    w_state_next = S_ERROR; w_err_code = 4'd3;
                end else if (w_args_nil) begin
                    w_state_next = w_depth0 ? S_DONE : S_RETURN;
                end else begin
                    w_rd = 1'b1; w_rd_addr = r_args; w_rd_cont = C_ARGS;
                end
            end
            S_RETURN: begin
                w_pop = 1'b1; w_state_next = S_COMBINE;
            end
            default: begin
                w_state_next = S_ERROR; w_err_code = 4'd0;
            end
        endcase
        if (w_rd) w_state_next = S_MEM_WAIT;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Datapath: memory port, cell latch, accumulator, frame registers, status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_cont     <= C_EVAL;
            r_wait     <= '0;
            r_root     <= '0;
            r_hdr      <= '0;
            r_car      <= '0;
            r_cdr      <= '0;
            r_op       <= '0;
            r_acc      <= '0;
            r_args     <= LISP_NIL;
            r_value    <= '0;
            r_result   <= LISP_NIL;
            r_first    <= 1'b0;
            r_depth    <= '0;
            r_err_code <= 4'd0;
        end else begin
            r_mem_req <= 1'b0;
            if (w_rd) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_rd_addr;
                r_cont     <= w_rd_cont;
                r_wait     <= '0;
            end
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_root     <= expr_addr;
                        r_acc      <= '0;
                        r_depth    <= '0;
                        r_err_code <= 4'd0;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem.mem_ready) begin
                        r_hdr <= mem.mem_header;
                        r_car <= mem.mem_car;
                        r_cdr <= mem.mem_cdr;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                S_EVAL: begin
                    if (w_is_num) begin
                        r_value <= r_car;
                        if (w_depth0) r_result <= r_car;
                    end else if (w_is_cons) begin
                        r_args  <= r_cdr;
                        r_first <= 1'b1;
                    end
                end
                S_APPLY: r_op <= r_car;
                S_EVAL_ARGS: begin
                    if (r_cont != C_ARG && w_is_cons) r_args <= r_cdr;
                    if (r_cont == C_ARG && w_is_num) r_value <= r_car;
                    if (w_push) r_depth <= r_depth + DW'(1);
                end
                S_COMBINE: begin
                    r_acc   <= w_comb_val;
                    r_first <= 1'b0;
                    if (w_args_nil) begin
                        r_value <= w_comb_val;
                        if (w_depth0) r_result <= w_comb_val;
                    end
                end
                S_RETURN: begin
                    r_op    <= r_stk_op[w_pop_idx];
                    r_acc   <= r_stk_acc[w_pop_idx];
                    r_args  <= r_stk_args[w_pop_idx];
                    r_first <= r_stk_first[w_pop_idx];
                    r_depth <= r_depth - DW'(1);
                end
                default: ;
            endcase
            if (w_state_next == S_ERROR && r_state != S_ERROR) r_err_code <= w_err_code;
        end
    end

    // Frame storage; occupancy is tracked by r_depth so entries need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stk_op[w_push_idx]    <= r_op;
            r_stk_acc[w_push_idx]   <= r_acc;
            r_stk_args[w_push_idx]  <= r_args;
            r_stk_first[w_push_idx] <= r_first;
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign busy         = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
    assign error_code   = r_err_code;
    assign result       = r_result;
    assign depth        = r_depth;
endmodule

// File: doc/lisp_eval_core.md
LISP_EVAL_CORE -- requirements
Module: lisp_eval_core

Interface
REQ-001 Parameter WORD_W, default 16: width of numbers, cell addresses and car/cdr fields.
REQ-002 Parameter STACK_DEPTH, default 8: maximum number of suspended nested-application frames.
REQ-003 Parameter MEM_TIMEOUT, default 255: cycles to wait for mem_ready before faulting.
REQ-004 Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
REQ-005 Ports (name direction width meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous reset, active-low.
  start  in  1  one-cycle request to evaluate the expression at expr_addr.
  expr_addr  in  WORD_W  root cell address.
  mem_req  out  1  one-cycle cell-read request.
  mem_addr  out  WORD_W  cell address, held stable from mem_req until mem_ready.
  mem_ready  in  1  mem_header/mem_car/mem_cdr valid this cycle.
  mem_header  in  15  cell type tag (lisp_defs TYPE_*).
  mem_car  in  WORD_W  car field.
  mem_cdr  in  WORD_W  cdr field.
  busy  out  1  evaluation in progress.
  done  out  1  result valid.
  result  out  WORD_W  evaluated value.
  error  out  1  evaluation faulted.
  error_code  out  4  fault cause.
  depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy.

Function
REQ-006 States SHALL be Idle, Fetch, MemWait, Eval, Apply, EvalArgs, Combine, Return, Done and Error; each state SHALL take one cycle except MemWait.
REQ-007 In Idle, Done or Error, start SHALL latch expr_addr, clear acc, depth and error, and enter Fetch; while busy, start SHALL be ignored.
REQ-008 Fetch and every cell read SHALL pulse mem_req for one cycle with mem_addr, then enter MemWait, which exits on mem_ready to the continuation state; the cell fields SHALL be latched on that cycle.
REQ-009 mem_ready outside MemWait SHALL be ignored; if MEM_TIMEOUT cycles pass in MemWait, the block SHALL enter Error with code 1.
REQ-010 Eval, TYPE_NUMBER: the value is the car; go to Done if depth is 0, else Return.
REQ-011 Eval, TYPE_CONS: set args to the cdr, set the first flag, and read the car, continuing to Apply.
REQ-012 Eval, any other type: enter Error with code 2.
REQ-013 Apply SHALL require TYPE_PRIMITIVE (else Error code 3), latch op from the car, and with args equal to LISP_NIL SHALL enter Error code 5 (arity); otherwise read args, continuing to EvalArgs.
REQ-014 EvalArgs SHALL require TYPE_CONS (else Error code 2), set args to the cdr, and read the car (the argument) with an EvalArgs-argument continuation.
REQ-015 The argument cell: TYPE_NUMBER goes to Combine with the car.
REQ-016 The argument cell: TYPE_CONS SHALL push the frame {op, acc, args, first} and re-enter Eval on that cell; if depth equals STACK_DEPTH, enter Error code 4.
REQ-017 Combine with first set: acc = value and first is cleared.
REQ-018 Combine with first clear: acc = acc OP value for lisp_defs PRIMOP_ADD (+), PRIMOP_SUB (-), PRIMOP_MUL (low WORD_W bits of the product), PRIMOP_AND and PRIMOP_OR; any other op gives Error code 3.
REQ-019 All arithmetic SHALL wrap modulo 2^WORD_W.
REQ-020 After Combine: if args is LISP_NIL, the value is acc and the block goes to Done (depth 0) or Return (depth > 0); otherwise it reads args, continuing to EvalArgs.
REQ-021 Return SHALL pop a frame and go to Combine with the nested value.
REQ-022 Push and pop SHALL never occur in the same cycle.
REQ-023 busy SHALL be high in every state except Idle, Done and Error.
REQ-024 done SHALL be high only in Done, with result holding its value until the next start.
REQ-025 error SHALL be high only in Error, with error_code latched on entry; error code 0 means an illegal state was entered.
REQ-026 Error and Done SHALL be sticky until start or reset.

Reset
REQ-027 While rst is 0, the block SHALL immediately reach Idle.
REQ-028 Reset values SHALL be: mem_req=0, mem_addr=0, busy=0, done=0, error=0, error_code=0, result=LISP_NIL, depth=0, stack empty.
REQ-029 Reset mid-evaluation SHALL abandon the evaluation, with no mem_req issued after release until a new start.

Verification
REQ-030 Number cell at 0x10 (car 7), start -> exactly one read, done=1, result=7, depth=0.
REQ-031 (+ 1 2 3) list at 0x20 -> done, result=6; four-cycle mem latency and single-cycle latency both pass.
REQ-032 (- 10 (* 2 3)) -> peak depth=1, result=4; (- 0 1) with WORD_W=16 -> result=0xFFFF.
REQ-033 STACK_DEPTH=2 with three nested conses -> error=1, error_code=4, no further mem_req.
REQ-034 mem_ready withheld -> error_code=1 exactly MEM_TIMEOUT cycles after mem_req; a car of TYPE_NUMBER in operator position -> error_code=3; (+) -> error_code=5.
REQ-035 rst low during MemWait, then start on 0x10 -> result=7 and stale mem_ready ignored.
